param_counter: RTL and testbench

Parametrised modulo-N counter with enable, synchronous set/load, clock prescaler and registered wrap pulse. It is the next generation of the team's 4-bit counter. Width, modulus and count rate are generalised, and a data load path plus a terminal-count strobe for cascading are added. It sits in the timing/counter section of the design and feeds downstream flip-flop and display logic.

---
 rtl/counter_pkg.sv | 32 +++
 rtl/counter_prescaler.sv | 34 +++
 rtl/param_counter.sv | 93 +++++++++
 tb/tb_param_counter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised counter family: direction
// constants, prescaler sizing and the parameter legality check.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // The prescaler register is never narrower than one bit.
  function automatic int unsigned prescale_width(input int unsigned prescale);
    return (clog2(prescale) < 1) ? 1 : clog2(prescale);
  endfunction

  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned modulus,
                                   input int unsigned prescale,
                                   input int unsigned reset_val);
    return (width >= 1) && (modulus >= 2) &&
           (64'(modulus) <= (64'd1 << width)) &&
           (prescale >= 1) && (reset_val < modulus);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Count-rate prescaler: emits a one-cycle tick on every PRESCALE-th
// enabled edge. Internally a down-counter; a terminal count of zero marks
// the step edge. Clearing (SET/LOAD) restarts the full PRESCALE interval.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] remain;

  assign tick = en && !clr && (remain == '0);

  // Remaining enabled edges before the next step; holds while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remain <= LAST;
    end else if (clr) begin
      remain <= LAST;
    end else if (en) begin
      remain <= (remain == '0) ? LAST : remain - PW'(1);
    end
  end

endmodule

// File: rtl/param_counter.sv
// Parametrised modulo-MODULUS counter with enable, synchronous SET/LOAD,
// clock prescaler and registered WRAP pulse for cascading.
// Optional feature macro: COUNTER_UPDOWN_EN adds the UP port and
// bidirectional counting; without it the counter steps up only.
module param_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             set,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
`ifdef COUNTER_UPDOWN_EN
  input  logic             up,
`endif
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  generate
    if (!params_ok(WIDTH, MODULUS, PRESCALE, RESET_VAL)) begin : g_bad_params
      $error("param_counter: illegal WIDTH/MODULUS/PRESCALE/RESET_VAL");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULUS);

  logic             tick;
  logic             dir;
  logic             at_end;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH:0]   d_ext;

  counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (set | load),
    .tick  (tick)
  );

`ifdef COUNTER_UPDOWN_EN
  assign dir = up;
`else
  assign dir = CNT_UP;
`endif

  // Out-of-range load data folds back into 0..MODULUS-1.
  assign d_ext    = {1'b0, d};
  assign load_val = WIDTH'(d_ext % MOD_W);

  // Next value for a count step and whether that step wraps.
  always_comb begin
    at_end   = 1'b0;
    step_val = count;
    if (dir == CNT_UP) begin
      at_end   = (count == MAX_VAL);
      step_val = at_end ? '0 : count + WIDTH'(1);
    end else begin
      at_end   = (count == '0);
      step_val = at_end ? MAX_VAL : count - WIDTH'(1);
    end
  end

  // Count register with SET > LOAD > step priority; WRAP follows the step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= RST_VAL;
      wrap  <= 1'b0;
    end else if (set) begin
      count <= MAX_VAL;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
    end else if (tick) begin
      count <= step_val;
      wrap  <= at_end;
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter: three instances with different
// modulus/prescale/reset values share one stimulus stream and are compared
// each cycle against an arithmetic reference model.
module tb_param_counter;

  localparam int M  [3] = '{10, 10, 16};
  localparam int P  [3] = '{1, 3, 1};
  localparam int RV [3] = '{0, 5, 0};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en_drv = 1'b0;
  logic       set_drv = 1'b0;
  logic       load_drv = 1'b0;
  logic [3:0] d_drv = '0;
  logic       up_drv = 1'b1;
  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic [3:0] obs_cnt [3];
  logic       obs_wrap [3];

  int m_cnt [3];
  int m_pre [3];
  int m_wrap [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .RESET_VAL(0)) dut_a (
    .clk(clk), .reset(reset), .en(en_drv), .set(set_drv), .load(load_drv), .d(d_drv),
`ifdef COUNTER_UPDOWN_EN
    .up(up_drv),
`endif
    .count(cnt_a), .wrap(wrap_a));

  param_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .RESET_VAL(5)) dut_b (
    .clk(clk), .reset(reset), .en(en_drv), .set(set_drv), .load(load_drv), .d(d_drv),
`ifdef COUNTER_UPDOWN_EN
    .up(up_drv),
`endif
    .count(cnt_b), .wrap(wrap_b));

  param_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .RESET_VAL(0)) dut_c (
    .clk(clk), .reset(reset), .en(en_drv), .set(set_drv), .load(load_drv), .d(d_drv),
`ifdef COUNTER_UPDOWN_EN
    .up(up_drv),
`endif
    .count(cnt_c), .wrap(wrap_c));

  assign obs_cnt[0] = cnt_a;
  assign obs_cnt[1] = cnt_b;
  assign obs_cnt[2] = cnt_c;
  assign obs_wrap[0] = wrap_a;
  assign obs_wrap[1] = wrap_b;
  assign obs_wrap[2] = wrap_c;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = RV[k];
      m_pre[k] = 0;
      m_wrap[k] = 0;
    end
  endtask

  // Reference behaviour of one rising edge, from the inputs driven before it.
  task automatic model_edge();
    bit dir;
`ifdef COUNTER_UPDOWN_EN
    dir = up_drv;
`else
    dir = 1'b1;
`endif
    for (int k = 0; k < 3; k++) begin
      if (set_drv) begin
        m_cnt[k] = M[k] - 1; m_pre[k] = 0; m_wrap[k] = 0;
      end else if (load_drv) begin
        m_cnt[k] = int'(d_drv) % M[k]; m_pre[k] = 0; m_wrap[k] = 0;
      end else if (en_drv) begin
        m_pre[k] = (m_pre[k] + 1) % P[k];
        if (m_pre[k] == 0) begin
          if (dir) begin
            m_cnt[k] = (m_cnt[k] + 1) % M[k];
            m_wrap[k] = (m_cnt[k] == 0);
          end else begin
            m_cnt[k] = (m_cnt[k] + M[k] - 1) % M[k];
            m_wrap[k] = (m_cnt[k] == M[k] - 1);
          end
        end else begin
          m_wrap[k] = 0;
        end
      end else begin
        m_wrap[k] = 0;
      end
    end
  endtask

  task automatic do_edge();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  // Mid-cycle asynchronous reset pulse, released before the next edge.
  task automatic apply_reset();
    #2 reset = 1'b0;
    #1 model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    set_drv = 0; load_drv = 0; en_drv = 0; d_drv = 0; up_drv = 1;
    reset = 1'b0;
    #20;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_cnt[k] !== 4'(RV[k]) || obs_wrap[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold dut%0d count=%0d wrap=%b want count=%0d wrap=0",
                 k, obs_cnt[k], obs_wrap[k], RV[k]);
      end
    end
    reset = 1'b1;
    load_drv = 1; d_drv = 4'd7;
    do_edge();
    load_drv = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_cnt[k] !== 4'(m_cnt[k])) begin
        errors++;
        $display("FAIL load7 dut%0d count=%0d want %0d", k, obs_cnt[k], m_cnt[k]);
      end
    end
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_cnt[k] !== 4'(RV[k]) || obs_wrap[k] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset dut%0d count=%0d wrap=%b want count=%0d wrap=0",
                 k, obs_cnt[k], obs_wrap[k], RV[k]);
      end
    end
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_up_wrap();
    apply_reset();
    up_drv = 1; en_drv = 1;
    for (int i = 0; i < 10; i++) begin
      do_edge();
      checks++;
      if (cnt_a !== 4'((i + 1) % 10) || wrap_a !== (i == 9)) begin
        errors++;
        $display("FAIL up_wrap edge%0d count=%0d wrap=%b want count=%0d wrap=%b",
                 i, cnt_a, wrap_a, (i + 1) % 10, (i == 9));
      end
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (obs_cnt[k] !== 4'(m_cnt[k]) || obs_wrap[k] !== m_wrap[k][0]) begin
          errors++;
          $display("FAIL up_model dut%0d count=%0d wrap=%b want count=%0d wrap=%0d",
                   k, obs_cnt[k], obs_wrap[k], m_cnt[k], m_wrap[k]);
        end
      end
    end
    en_drv = 0;
  endtask

`ifdef COUNTER_UPDOWN_EN
  task automatic test_down_wrap();
    load_drv = 1; d_drv = 4'd1;
    do_edge();
    load_drv = 0; up_drv = 0; en_drv = 1;
    for (int i = 0; i < 2; i++) begin
      do_edge();
      checks++;
      if (cnt_a !== ((i == 0) ? 4'd0 : 4'd9) || wrap_a !== (i == 1)) begin
        errors++;
        $display("FAIL down_wrap edge%0d count=%0d wrap=%b want count=%0d wrap=%b",
                 i, cnt_a, wrap_a, (i == 0) ? 0 : 9, (i == 1));
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_cnt[k] !== 4'(m_cnt[k]) || obs_wrap[k] !== m_wrap[k][0]) begin
          errors++;
          $display("FAIL down_model dut%0d count=%0d wrap=%b want count=%0d wrap=%0d",
                   k, obs_cnt[k], obs_wrap[k], m_cnt[k], m_wrap[k]);
        end
      end
    end
    en_drv = 0; up_drv = 1;
  endtask
`endif

  task automatic test_prescaler();
    int want_b [8] = '{5, 5, 6, 6, 6, 7, 7, 7};
    apply_reset();
    up_drv = 1;
    for (int i = 0; i < 13; i++) begin
      en_drv = (i == 0 || i >= 6);
      do_edge();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_cnt[k] !== 4'(m_cnt[k]) || obs_wrap[k] !== m_wrap[k][0]) begin
          errors++;
          $display("FAIL prescale_model edge%0d dut%0d count=%0d wrap=%b want count=%0d wrap=%0d",
                   i, k, obs_cnt[k], obs_wrap[k], m_cnt[k], m_wrap[k]);
        end
      end
      if (i < 6) begin
        checks++;
        if (cnt_b !== 4'd5) begin
          errors++;
          $display("FAIL prescale_hold edge%0d count=%0d want 5", i, cnt_b);
        end
      end else begin
        checks++;
        if (cnt_b !== 4'(want_b[i - 6 + 1])) begin
          errors++;
          $display("FAIL prescale_resume edge%0d count=%0d want %0d", i, cnt_b, want_b[i - 6 + 1]);
        end
      end
    end
    en_drv = 0;
  endtask

  task automatic test_load_set();
    logic [3:0] d_seq [3] = '{4'd6, 4'd12, 4'd3};
    logic [3:0] want  [3] = '{4'd6, 4'd2, 4'd9};
    en_drv = 1;
    for (int i = 0; i < 3; i++) begin
      load_drv = 1; d_drv = d_seq[i]; set_drv = (i == 2);
      do_edge();
      checks++;
      if (cnt_a !== want[i] || wrap_a !== 1'b0) begin
        errors++;
        $display("FAIL load_set step%0d count=%0d wrap=%b want count=%0d wrap=0",
                 i, cnt_a, wrap_a, want[i]);
      end
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (obs_cnt[k] !== 4'(m_cnt[k]) || obs_wrap[k] !== m_wrap[k][0]) begin
          errors++;
          $display("FAIL load_model dut%0d count=%0d wrap=%b want count=%0d wrap=%0d",
                   k, obs_cnt[k], obs_wrap[k], m_cnt[k], m_wrap[k]);
        end
      end
    end
    load_drv = 0; set_drv = 0; en_drv = 0;
  endtask

  task automatic test_config();
    int wraps = 0;
    apply_reset();
    up_drv = 1; en_drv = 1;
    for (int i = 0; i < 20; i++) begin
      do_edge();
      if (wrap_c === 1'b1) wraps++;
    end
    en_drv = 0;
    checks++;
    if (cnt_c !== 4'(20 % 16)) begin
      errors++;
      $display("FAIL config_count count=%0d want %0d", cnt_c, 20 % 16);
    end
    checks++;
    if (wraps != 20 / 16) begin
      errors++;
      $display("FAIL config_wraps wraps=%0d want %0d", wraps, 20 / 16);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en_drv   = ($urandom_range(3, 0) != 0);
      set_drv  = ($urandom_range(19, 0) == 0);
      load_drv = ($urandom_range(11, 0) == 0);
      d_drv    = 4'($urandom_range(15, 0));
      up_drv   = 1'($urandom_range(1, 0));
      if (i % 97 == 50) apply_reset();
      do_edge();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_cnt[k] !== 4'(m_cnt[k]) || obs_wrap[k] !== m_wrap[k][0]) begin
          errors++;
          $display("FAIL random cyc%0d dut%0d count=%0d wrap=%b want count=%0d wrap=%0d",
                   i, k, obs_cnt[k], obs_wrap[k], m_cnt[k], m_wrap[k]);
        end
      end
    end
    en_drv = 0; set_drv = 0; load_drv = 0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
`ifdef COUNTER_UPDOWN_EN
    test_down_wrap();
`endif
    test_prescaler();
    test_load_set();
    test_config();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
